// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer: op codes, FSM states, legality check.
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_MULT = 4'b1000,
        OP_DIV  = 4'b1010,
        OP_MTHI = 4'b0001,
        OP_MTLO = 4'b0011,
        OP_MFHI = 4'b0100,
        OP_MFLO = 4'b0110
    } op_t;

    // Any code with bit 2 set leaves HI/LO untouched in the datapath.
    localparam logic [3:0] F_IDLE = 4'b0100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_COMMIT,
        S_READ,
        S_RESP
    } state_t;

    function automatic logic is_legal(input logic [3:0] f);
        case (f)
            OP_MULT, OP_DIV, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_rr_arb.sv
// Two-way round-robin arbiter; the pointer flips to the other port after every granted transfer.
module muldiv_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       grant_idx
);

    logic ptr;

    // NOTE: grant_idx is assigned before the conditional override so no latch is inferred.
    always_comb begin
        grant_idx = ptr;
        if (!valid[ptr])
            grant_idx = ~ptr;
        grant = valid[grant_idx] ? (2'b01 << grant_idx) : 2'b00;
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            ptr <= 1'b0;
        else if (advance)
            ptr <= ~grant_idx;
    end

endmodule

// File: rtl/muldiv_sched.sv
// Sequencer/arbiter in front of the multiply_divide HI/LO datapath.
// Optional feature: define MULDIV_DIVZERO_TRAP_EN to trap DIV by zero without touching HI/LO.
module muldiv_sched
    import muldiv_pkg::*;
#(
    parameter int n       = 32,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [3:0]   req_op0,
    input  logic [3:0]   req_op1,
    input  logic [n-1:0] req_a0,
    input  logic [n-1:0] req_b0,
    input  logic [n-1:0] req_a1,
    input  logic [n-1:0] req_b1,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [n-1:0] rsp_data,
    output logic         rsp_err,
    output logic [3:0]   md_F,
    output logic [n-1:0] md_a,
    output logic [n-1:0] md_b,
    input  logic [n-1:0] md_y,
    output logic         busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    op_q;
    logic [3:0]    md_f_q;
    logic [1:0]    grant;
    logic          gidx;
    logic          accept;
    logic          div_trap;
    logic [3:0]    sel_op;
    logic [n-1:0]  sel_a;
    logic [n-1:0]  sel_b;

    muldiv_rr_arb u_arb (
        .clk       (clk),
        .reset     (reset),
        .valid     (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (gidx)
    );

    assign req_ready = (state == S_IDLE && !reset) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign sel_op    = gidx ? req_op1 : req_op0;
    assign sel_a     = gidx ? req_a1  : req_a0;
    assign sel_b     = gidx ? req_b1  : req_b0;

`ifdef MULDIV_DIVZERO_TRAP_EN
    assign div_trap = (sel_b == '0);
`else
    assign div_trap = 1'b0;
`endif

    // Gating on reset kills a COMMIT that is already on the bus in the reset cycle.
    assign md_F = reset ? F_IDLE : md_f_q;
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_q      <= F_IDLE;
            md_f_q    <= F_IDLE;
            md_a      <= '0;
            md_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q     <= sel_op;
                        md_a     <= sel_a;
                        md_b     <= sel_b;
                        rsp_id   <= gidx;
                        rsp_data <= '0;
                        rsp_err  <= 1'b0;
                        if (!is_legal(sel_op) || (sel_op == OP_DIV && div_trap)) begin
                            state     <= S_RESP;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                        end else begin
                            case (sel_op)
                                OP_MULT: begin
                                    if (MUL_LAT == 1) begin
                                        state  <= S_COMMIT;
                                        md_f_q <= sel_op;
                                    end else begin
                                        state <= S_EXEC;
                                        cnt   <= CW'(MUL_LAT - 1);
                                    end
                                end
                                OP_DIV: begin
                                    if (DIV_LAT == 1) begin
                                        state  <= S_COMMIT;
                                        md_f_q <= sel_op;
                                    end else begin
                                        state <= S_EXEC;
                                        cnt   <= CW'(DIV_LAT - 1);
                                    end
                                end
                                OP_MTHI, OP_MTLO: begin
                                    state  <= S_COMMIT;
                                    md_f_q <= sel_op;
                                end
                                default: begin
                                    state  <= S_READ;
                                    md_f_q <= sel_op;
                                end
                            endcase
                        end
                    end
                end
                S_EXEC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state  <= S_COMMIT;
                        md_f_q <= op_q;
                    end
                end
                S_COMMIT: begin
                    state     <= S_RESP;
                    md_f_q    <= F_IDLE;
                    rsp_valid <= 1'b1;
                end
                S_READ: begin
                    state     <= S_RESP;
                    md_f_q    <= F_IDLE;
                    rsp_data  <= md_y;
                    rsp_valid <= 1'b1;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        md_a      <= '0;
                        md_b      <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched: a HI/LO datapath stand-in plus a per-transaction reference model.
module tb_muldiv_sched;
    import muldiv_pkg::*;

    localparam int N       = 32;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [3:0]    req_op0, req_op1;
    logic [N-1:0]  req_a0, req_b0, req_a1, req_b1;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [N-1:0]  rsp_data;
    logic [3:0]    md_F;
    logic [N-1:0]  md_a, md_b, md_y;
    logic          busy;

    int total = 0;
    int bad   = 0;

    // Reference HI/LO as seen at transaction granularity.
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    always #5 clk = ~clk;

    muldiv_sched #(.n(N), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op0   (req_op0),
        .req_op1   (req_op1),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .md_F      (md_F),
        .md_a      (md_a),
        .md_b      (md_b),
        .md_y      (md_y),
        .busy      (busy)
    );

    // Stand-in for the multiply_divide datapath: writes HI/LO on the edge that ends a write code.
    logic [31:0] hi_r, lo_r;
    always @(posedge clk) begin
        case (md_F)
            4'b1000: {hi_r, lo_r} <= {32'd0, md_a} * {32'd0, md_b};
            4'b1010: begin
                if (md_b != 32'd0) begin
                    lo_r <= md_a / md_b;
                    hi_r <= md_a % md_b;
                end else begin
                    lo_r <= '1;
                    hi_r <= md_a;
                end
            end
            4'b0001: hi_r <= md_a;
            4'b0011: lo_r <= md_a;
            default: ;
        endcase
    end
    assign md_y = (md_F == 4'b0110) ? lo_r : hi_r;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected response, latency (cycles after acceptance) and commit cycle (-1 = none).
    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] d, output logic e, output int lat, output int cmt);
        logic [63:0] p;
        d = 32'd0; e = 1'b0; cmt = -1; lat = 1;
        case (op)
            OP_MULT: begin
                p = 64'(a) * 64'(b);
                hi_m = p[63:32]; lo_m = p[31:0];
                lat = MUL_LAT + 1; cmt = MUL_LAT;
            end
            OP_DIV: begin
`ifdef MULDIV_DIVZERO_TRAP_EN
                if (b == 32'd0) begin
                    e = 1'b1; lat = 1;
                end else begin
                    lo_m = a / b; hi_m = a % b;
                    lat = DIV_LAT + 1; cmt = DIV_LAT;
                end
`else
                if (b == 32'd0) begin
                    lo_m = '1; hi_m = a;
                end else begin
                    lo_m = a / b; hi_m = a % b;
                end
                lat = DIV_LAT + 1; cmt = DIV_LAT;
`endif
            end
            OP_MTHI: begin hi_m = a; lat = 2; cmt = 1; end
            OP_MTLO: begin lo_m = a; lat = 2; cmt = 1; end
            OP_MFHI: begin d = hi_m; lat = 2; end
            OP_MFLO: begin d = lo_m; lat = 2; end
            default: begin e = 1'b1; lat = 1; end
        endcase
    endtask

    task automatic set_port(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            req_op0 = op; req_a0 = a; req_b0 = b;
        end else begin
            req_op1 = op; req_a1 = a; req_b1 = b;
        end
        req_valid[p] = 1'b1;
    endtask

    // Returns just after the accepting edge, i.e. at the start of cycle 1.
    task automatic wait_accept(input int p, output int waited, output logic [1:0] rr);
        waited = 0;
        @(negedge clk);
        while (!req_ready[p] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        rr = req_ready;
        if (!req_ready[p])
            check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 req_valid[p] = 1'b0;
    endtask

    task automatic track(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] d, input logic e, input int lat, input int cmt,
                         input int hold, input string tag);
        int cyc = 0, commits = 0, cmt_at = -1;
        bit got = 0, rdy_ok = 1, opnd_ok = 1, stable = 1;
        rsp_ready = (hold == 0);
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (md_F[2] == 1'b0) begin commits++; cmt_at = cyc; end
            if (req_ready !== 2'b00) rdy_ok = 0;
            if (md_a !== a || md_b !== b) opnd_ok = 0;
            if (rsp_valid === 1'b1) got = 1;
        end
        if (!got) begin
            check({tag, "_rsp_timeout"}, 32'd0, 32'd1);
            rsp_ready = 1'b1;
            return;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        check({tag, "_id"}, 32'(rsp_id), 32'(id));
        check({tag, "_data"}, rsp_data, d);
        check({tag, "_err"}, 32'(rsp_err), 32'(e));
        check({tag, "_commits"}, 32'(commits), (cmt >= 0) ? 32'd1 : 32'd0);
        check({tag, "_commit_cycle"}, 32'(cmt_at), 32'(cmt));
        check({tag, "_ready_low"}, 32'(rdy_ok), 32'd1);
        check({tag, "_operands"}, 32'(opnd_ok), 32'd1);
        for (int h = 1; h < hold; h++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_id !== id || rsp_err !== e || req_ready !== 2'b00)
                stable = 0;
        end
        if (hold > 0) begin
            check({tag, "_stall_stable"}, 32'(stable), 32'd1);
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string tag);
        logic [31:0] d; logic e; int lat, cmt, w; logic [1:0] rr;
        model_op(op, a, b, d, e, lat, cmt);
        set_port(p, op, a, b);
        wait_accept(p, w, rr);
        track(1'(p), a, b, d, e, lat, cmt, hold, tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Assert reset in cycle rc of a MULT; HI/LO must not be written (model left unchanged).
    task automatic reset_mid_mult(input int rc, input string tag);
        int w; logic [1:0] rr;
        set_port(0, OP_MULT, 32'd3, 32'd5);
        wait_accept(0, w, rr);
        for (int c = 1; c < rc; c++) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        check({tag, "_ready_in_reset"}, 32'(req_ready), 32'd0);
        check({tag, "_mdF_in_reset"}, 32'(md_F), 32'(F_IDLE));
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_mdF_after"}, 32'(md_F), 32'(F_IDLE));
        check({tag, "_rsp_valid_after"}, 32'(rsp_valid), 32'd0);
        check({tag, "_md_a_after"}, md_a, 32'd0);
    endtask

    initial begin
        logic [31:0] d0, d1;
        logic e0, e1;
        int lat0, cmt0, lat1, cmt1, w;
        logic [1:0] rr;
        logic [3:0] op_tbl [8];

        reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
        req_op0 = 4'd0; req_op1 = 4'd0;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        repeat (2) @(posedge clk);
        req_valid = 2'b11;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_md_F", 32'(md_F), 32'(F_IDLE));
        check("rst_md_a", md_a, 32'd0);
        check("rst_md_b", md_b, 32'd0);
        req_valid = 2'b00;
        @(posedge clk);
        #1 reset = 1'b0;

        // MULT then reads on port 0
        do_op(0, OP_MULT, 32'd7, 32'd6, 0, "s1_mult");
        do_op(0, OP_MFLO, 32'd0, 32'd0, 0, "s1_mflo");
        check("s1_lo_is_42", lo_m, 32'd42);
        do_op(0, OP_MFHI, 32'd0, 32'd0, 0, "s1_mfhi");

        // DIV on port 1
        do_op(1, OP_DIV, 32'd100, 32'd7, 0, "s2_div");
        do_op(1, OP_MFLO, 32'd0, 32'd0, 0, "s2_mflo");
        do_op(1, OP_MFHI, 32'd0, 32'd0, 0, "s2_mfhi");
        check("s2_hi_is_2", hi_m, 32'd2);

        // Simultaneous requests right after reset: port 0 first, then port 1
        do_reset();
        set_port(0, OP_MTHI, 32'h11, 32'd0);
        set_port(1, OP_MTHI, 32'h22, 32'd0);
        model_op(OP_MTHI, 32'h11, 32'd0, d0, e0, lat0, cmt0);
        wait_accept(0, w, rr);
        check("s3_first_grant", 32'(rr), 32'd1);
        track(1'b0, 32'h11, 32'd0, d0, e0, lat0, cmt0, 0, "s3_p0");
        model_op(OP_MTHI, 32'h22, 32'd0, d1, e1, lat1, cmt1);
        wait_accept(1, w, rr);
        check("s3_second_grant", 32'(rr), 32'd2);
        track(1'b1, 32'h22, 32'd0, d1, e1, lat1, cmt1, 0, "s3_p1");
        do_op(0, OP_MFHI, 32'd0, 32'd0, 0, "s3_mfhi");
        check("s3_hi_is_22", hi_m, 32'h22);

        // Divide by zero
        do_op(0, OP_MTHI, 32'h55, 32'd0, 0, "s4_mthi");
        do_op(1, OP_DIV, 32'd9, 32'd0, 0, "s4_div0");
        do_op(0, OP_MFHI, 32'd0, 32'd0, 0, "s4_mfhi");

        // Reset in the middle of a MULT, and during its COMMIT cycle
        do_op(0, OP_MTLO, 32'hABCD, 32'd0, 0, "s5_mtlo");
        do_op(1, OP_MTHI, 32'h1234, 32'd0, 0, "s5_mthi");
        reset_mid_mult(2, "s5_rst_c2");
        do_op(0, OP_MFLO, 32'd0, 32'd0, 0, "s5_mflo_a");
        reset_mid_mult(MUL_LAT, "s5_rst_commit");
        do_op(0, OP_MFLO, 32'd0, 32'd0, 0, "s5_mflo_b");
        do_op(1, OP_MFHI, 32'd0, 32'd0, 0, "s5_mfhi");

        // Response back-pressure, then immediate next accept
        do_op(1, OP_MFLO, 32'd0, 32'd0, 5, "s6_stall");
        set_port(0, OP_MFHI, 32'd0, 32'd0);
        model_op(OP_MFHI, 32'd0, 32'd0, d0, e0, lat0, cmt0);
        wait_accept(0, w, rr);
        check("s6_accept_wait", 32'(w), 32'd0);
        track(1'b0, 32'd0, 32'd0, d0, e0, lat0, cmt0, 0, "s6_next");

        // Illegal codes
        do_op(1, 4'b1111, 32'h5, 32'h6, 0, "ill_f");
        do_op(0, 4'b0000, 32'h7, 32'h8, 2, "ill_0");

        // Randomized traffic
        op_tbl = '{OP_MULT, OP_DIV, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO, 4'b1111, 4'b0010};
        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            logic [31:0] a, b;
            op = op_tbl[$urandom_range(0, 7)];
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            do_op(int'($urandom_range(0, 1)), op, a, b, int'($urandom_range(0, 3)), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
